// File: rtl/i2c_master_byte_fsm.sv
// Purpose: byte-level I2C master sequencer (START, address, write/read bytes, ACK/NACK, STOP) driven by data_clk edges.
// Latency: every update lands one clk after the data_clk edge that causes it; edges are seen one clk after data_clk toggles.
// Backpressure: none; the host holds ena/addr/rw/data_wr stable from byte_done until the next data_clk rise.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   data_clk          data-phase clock from the clock generator (same domain as clk)
//   ena, addr, rw     host command: start or continue a transaction (rw 0=write, 1=read)
//   data_wr           byte to write
//   sda_in            sampled SDA line level
//   sda_oe            1 pulls SDA low, 0 releases it (open drain)
//   scl_ena           1 lets the SCL driver toggle
//   busy              transaction in progress
//   byte_done         one-clk pulse when a byte and its ACK phase complete
//   rd_data, rd_valid last received byte and its one-clk update pulse
//   ack_error         sticky slave NACK flag, cleared when a new transaction starts
module i2c_master_byte_fsm #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_clk,
    input  logic              ena,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rw,
    input  logic [DATA_W-1:0] data_wr,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              scl_ena,
    output logic              busy,
    output logic              byte_done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              ack_error
);

    // The bit counter must hold both the address index (ADDR_W, covering {addr,rw})
    // and the data index (DATA_W-1).
    localparam int CNT_MAX = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ACK_ADDR,
        S_WR,
        S_ACK_WR,
        S_RD,
        S_MACK,
        S_STOP
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W:0]     cmd_q, cmd_n;
    logic [DATA_W-1:0]   wr_q, wr_n;
    logic [DATA_W-1:0]   rx_q, rx_n;
    logic [CNT_W-1:0]    bit_cnt, cnt_n;
    logic [CNT_W-1:0]    bit_dec;
    logic                rx_done, rx_done_n;
    logic                sda_oe_n, scl_ena_n, busy_n, byte_done_n, rd_valid_n, ack_error_n;
    logic [DATA_W-1:0]   rd_data_n;

    logic data_clk_q;
    logic rise, fall, cont;

    // Plain edge-detect flop; left out of reset so a data_clk that is already
    // high when rst releases does not look like a fresh rise.
    always_ff @(posedge clk) begin
        data_clk_q <= data_clk;
    end

    assign rise    = data_clk & ~data_clk_q;
    assign fall    = ~data_clk & data_clk_q;
    assign cont    = ena && ({addr, rw} == cmd_q);
    assign bit_dec = bit_cnt - CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cmd_q     <= '0;
            wr_q      <= '0;
            rx_q      <= '0;
            bit_cnt   <= '0;
            rx_done   <= 1'b0;
            sda_oe    <= 1'b0;
            scl_ena   <= 1'b0;
            busy      <= 1'b0;
            byte_done <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            ack_error <= 1'b0;
        end else begin
            state     <= state_n;
            cmd_q     <= cmd_n;
            wr_q      <= wr_n;
            rx_q      <= rx_n;
            bit_cnt   <= cnt_n;
            rx_done   <= rx_done_n;
            sda_oe    <= sda_oe_n;
            scl_ena   <= scl_ena_n;
            busy      <= busy_n;
            byte_done <= byte_done_n;
            rd_data   <= rd_data_n;
            rd_valid  <= rd_valid_n;
            ack_error <= ack_error_n;
        end
    end

    always_comb begin
        state_n     = state;
        cmd_n       = cmd_q;
        wr_n        = wr_q;
        rx_n        = rx_q;
        cnt_n       = bit_cnt;
        rx_done_n   = rx_done;
        sda_oe_n    = sda_oe;
        scl_ena_n   = scl_ena;
        busy_n      = busy;
        byte_done_n = 1'b0;
        rd_data_n   = rd_data;
        rd_valid_n  = 1'b0;
        ack_error_n = ack_error;

        case (state)
            S_IDLE: begin
                if (rise && ena) begin
                    cmd_n       = {addr, rw};
                    wr_n        = data_wr;
                    ack_error_n = 1'b0;
                    busy_n      = 1'b1;
                    sda_oe_n    = 1'b1;     // START: SDA falls while SCL is still high
                    state_n     = S_START;
                end
            end

            S_START: begin
                if (fall) begin
                    scl_ena_n = 1'b1;
                end else if (rise) begin
                    sda_oe_n = ~cmd_q[ADDR_W];
                    cnt_n    = CNT_ADDR;
                    state_n  = S_ADDR;
                end
            end

            // bit_cnt holds the index of the bit currently on the bus; the rise
            // after index 0 has been driven releases SDA for the ACK slot.
            S_ADDR: begin
                if (rise) begin
                    if (bit_cnt == '0) begin
                        sda_oe_n = 1'b0;
                        state_n  = S_ACK_ADDR;
                    end else begin
                        cnt_n    = bit_dec;
                        sda_oe_n = ~cmd_q[bit_dec];
                    end
                end
            end

            S_ACK_ADDR: begin
                if (fall) begin
                    if (sda_in) begin
                        ack_error_n = 1'b1;
                    end
                end else if (rise) begin
                    if (ack_error) begin
                        sda_oe_n = 1'b1;
                        state_n  = S_STOP;
                    end else if (!cmd_q[0]) begin
                        sda_oe_n = ~wr_q[DATA_W-1];
                        cnt_n    = CNT_DATA;
                        state_n  = S_WR;
                    end else begin
                        sda_oe_n  = 1'b0;
                        cnt_n     = CNT_DATA;
                        rx_done_n = 1'b0;
                        state_n   = S_RD;
                    end
                end
            end

            S_WR: begin
                if (rise) begin
                    if (bit_cnt == '0) begin
                        sda_oe_n = 1'b0;
                        state_n  = S_ACK_WR;
                    end else begin
                        cnt_n    = bit_dec;
                        sda_oe_n = ~wr_q[bit_dec];
                    end
                end
            end

            S_ACK_WR: begin
                if (fall) begin
                    if (sda_in) begin
                        ack_error_n = 1'b1;
                    end
                    byte_done_n = 1'b1;
                end else if (rise) begin
                    if (cont && !ack_error) begin
                        wr_n     = data_wr;
                        sda_oe_n = ~data_wr[DATA_W-1];
                        cnt_n    = CNT_DATA;
                        state_n  = S_WR;
                    end else begin
                        sda_oe_n = 1'b1;
                        state_n  = S_STOP;
                    end
                end
            end

            // Samples arrive on falls; rx_done marks that the last one is in so
            // the following rise can hand the byte over without bit_cnt wrapping.
            S_RD: begin
                if (fall) begin
                    rx_n = {rx_q[DATA_W-2:0], sda_in};
                    if (bit_cnt == '0) begin
                        rx_done_n = 1'b1;
                    end else begin
                        cnt_n = bit_dec;
                    end
                end else if (rise && rx_done) begin
                    rd_data_n   = rx_q;
                    rd_valid_n  = 1'b1;
                    byte_done_n = 1'b1;
                    sda_oe_n    = cont;     // ACK to ask for more, NACK to finish
                    rx_done_n   = 1'b0;
                    state_n     = S_MACK;
                end
            end

            S_MACK: begin
                if (rise) begin
                    if (cont) begin
                        sda_oe_n  = 1'b0;
                        cnt_n     = CNT_DATA;
                        rx_done_n = 1'b0;
                        state_n   = S_RD;
                    end else begin
                        sda_oe_n = 1'b1;
                        state_n  = S_STOP;
                    end
                end
            end

            // Entered with SDA held low; SCL is parked, then SDA is released
            // so it rises while SCL is high.
            S_STOP: begin
                if (fall) begin
                    scl_ena_n = 1'b0;
                end else if (rise) begin
                    sda_oe_n = 1'b0;
                    busy_n   = 1'b0;
                    state_n  = S_IDLE;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_master_byte_fsm.sv
// Purpose: scoreboard bench for i2c_master_byte_fsm with a scripted slave and a bus-frame monitor.
// Latency: data_clk half period is HALF clk cycles, generated here.
// Backpressure: host inputs change only between byte_done and the next data_clk rise.
module tb_i2c_master_byte_fsm;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_clk;
    logic       ena;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] data_wr;
    logic       sda_in;
    logic       sda_oe;
    logic       scl_ena;
    logic       busy;
    logic       byte_done;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       ack_error;
    logic       slave_pull;

    int total = 0;
    int bad   = 0;
    int bd_cnt = 0;
    int rd_cnt = 0;

    typedef enum int {EV_NONE, EV_START, EV_FRAME, EV_STOP, EV_ABORT} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [8:0] val;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] rd_q[$];
    logic       slv_q[$];

    always #5 clk = ~clk;

    // Open-drain line: low if either side pulls.
    assign sda_in = ~sda_oe & ~slave_pull;

    i2c_master_byte_fsm #(.ADDR_W(7), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_clk  (data_clk),
        .ena       (ena),
        .addr      (addr),
        .rw        (rw),
        .data_wr   (data_wr),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .scl_ena   (scl_ena),
        .busy      (busy),
        .byte_done (byte_done),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .ack_error (ack_error)
    );

    initial begin
        data_clk = 1'b0;
        forever begin
            repeat (HALF) @(negedge clk);
            data_clk = ~data_clk;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic exp_ev(input ev_kind_t k, input logic [8:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        ev_q.push_back(e);
    endtask

    task automatic slv_byte(input logic [7:0] b, input logic ack_bit);
        for (int i = 7; i >= 0; i--) slv_q.push_back(b[i]);
        slv_q.push_back(ack_bit);
    endtask

    function automatic ev_t pop_ev();
        ev_t e;
        e.kind = EV_NONE;
        e.val  = '0;
        if (ev_q.size() != 0) e = ev_q.pop_front();
        return e;
    endfunction

    // Monitor plus scripted slave. Sampling at negedge clk + 1 sees data_clk
    // already toggled while DUT outputs still hold their pre-edge values.
    initial begin
        logic       prev_dc;
        logic       prev_busy;
        logic [8:0] bits;
        int         nbits;
        logic       sbit;
        logic       line;
        ev_t        e;
        prev_dc    = 1'b0;
        prev_busy  = 1'b0;
        bits       = '0;
        nbits      = 0;
        slave_pull = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (byte_done) bd_cnt++;
            if (rd_valid) begin
                rd_cnt++;
                if (rd_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_extra: got %0h want no read", rd_data);
                end else begin
                    check("rd_data", rd_data, rd_q.pop_front());
                end
            end
            if (busy && !prev_busy) begin
                e = pop_ev();
                check("ev_start", int'(e.kind), int'(EV_START));
                check("start_cond", {sda_oe, scl_ena}, 2'b10);
                nbits = 0;
            end
            if (!busy && prev_busy) begin
                e = pop_ev();
                if (e.kind == EV_ABORT) begin
                    check("abort_idle", {sda_oe, scl_ena}, 2'b00);
                end else begin
                    check("ev_stop", int'(e.kind), int'(EV_STOP));
                    check("stop_slots", nbits, 1);
                    check("stop_sda_low", bits[0], 1'b0);
                    check("stop_idle", {sda_oe, scl_ena}, 2'b00);
                end
                nbits = 0;
            end
            if (!data_clk && prev_dc && scl_ena) begin
                sbit = (slv_q.size() != 0) ? slv_q.pop_front() : 1'b1;
                slave_pull = ~sbit;
                line  = ~sda_oe & sbit;
                bits  = {bits[7:0], line};
                nbits++;
                if (nbits == 9) begin
                    e = pop_ev();
                    check("ev_frame", int'(e.kind), int'(EV_FRAME));
                    check("frame", bits, e.val);
                    nbits = 0;
                end
            end
            prev_dc   = data_clk;
            prev_busy = busy;
        end
    end

    task automatic wait_busy(input logic v, input string what);
        int n = 0;
        while (busy !== v && n < 5000) begin
            tick();
            n++;
        end
        check({"wait_busy_", what}, busy, v);
    endtask

    task automatic wait_bd(input int target, input string what);
        int n = 0;
        while (bd_cnt < target && n < 5000) begin
            tick();
            n++;
        end
        check({"wait_bd_", what}, bd_cnt, target);
    endtask

    task automatic wait_rd(input int target, input string what);
        int n = 0;
        while (rd_cnt < target && n < 5000) begin
            tick();
            n++;
        end
        check({"wait_rd_", what}, rd_cnt, target);
    endtask

    task automatic start_cmd(input logic [6:0] a, input logic r, input logic [7:0] d);
        addr    = a;
        rw      = r;
        data_wr = d;
        ena     = 1'b1;
    endtask

    task automatic end_test(input string name, input int bd0, input int exp_bd, input logic exp_err);
        wait_busy(1'b0, name);
        repeat (6) tick();
        check({name, "_byte_done"}, bd_cnt - bd0, exp_bd);
        check({name, "_ack_error"}, ack_error, exp_err);
        check({name, "_events_left"}, ev_q.size(), 0);
        check({name, "_reads_left"}, rd_q.size(), 0);
    endtask

    initial begin
        int bd0;
        rst     = 1'b1;
        ena     = 1'b0;
        addr    = '0;
        rw      = 1'b0;
        data_wr = '0;
        repeat (4) tick();
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_scl_ena", scl_ena, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_byte_done", byte_done, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_ack_error", ack_error, 1'b0);
        check("rst_rd_data", rd_data, 8'h00);
        rst = 1'b0;
        repeat (4) tick();

        // Single-byte write 0x50 <- 0xA5
        bd0 = bd_cnt;
        exp_ev(EV_START, '0);
        exp_ev(EV_FRAME, {8'hA0, 1'b0});
        exp_ev(EV_FRAME, {8'hA5, 1'b0});
        exp_ev(EV_STOP, '0);
        slv_byte(8'hFF, 1'b0); slv_byte(8'hFF, 1'b0); slv_q.push_back(1'b1);
        start_cmd(7'h50, 1'b0, 8'hA5);
        wait_busy(1'b1, "wr1");
        ena = 1'b0;
        end_test("wr1", bd0, 1, 1'b0);

        // Address NACK at 0x3C
        bd0 = bd_cnt;
        exp_ev(EV_START, '0);
        exp_ev(EV_FRAME, {8'h78, 1'b1});
        exp_ev(EV_STOP, '0);
        slv_byte(8'hFF, 1'b1); slv_q.push_back(1'b1);
        start_cmd(7'h3C, 1'b0, 8'h00);
        wait_busy(1'b1, "nack");
        ena = 1'b0;
        end_test("nack", bd0, 0, 1'b1);

        // Two-byte read from 0x68: 0x3C acked, 0xC3 nacked
        bd0 = bd_cnt;
        exp_ev(EV_START, '0);
        exp_ev(EV_FRAME, {8'hD1, 1'b0});
        exp_ev(EV_FRAME, {8'h3C, 1'b0});
        exp_ev(EV_FRAME, {8'hC3, 1'b1});
        exp_ev(EV_STOP, '0);
        rd_q.push_back(8'h3C);
        rd_q.push_back(8'hC3);
        slv_byte(8'hFF, 1'b0); slv_byte(8'h3C, 1'b1); slv_byte(8'hC3, 1'b1); slv_q.push_back(1'b1);
        start_cmd(7'h68, 1'b1, 8'h00);
        wait_rd(rd_cnt + 1, "rd1");
        @(posedge data_clk);
        repeat (2) tick();
        ena = 1'b0;
        end_test("rd2", bd0, 2, 1'b0);

        // Multi-byte write to 0x2A: 0x11 then 0x22, no STOP between
        bd0 = bd_cnt;
        exp_ev(EV_START, '0);
        exp_ev(EV_FRAME, {8'h54, 1'b0});
        exp_ev(EV_FRAME, {8'h11, 1'b0});
        exp_ev(EV_FRAME, {8'h22, 1'b0});
        exp_ev(EV_STOP, '0);
        slv_byte(8'hFF, 1'b0); slv_byte(8'hFF, 1'b0); slv_byte(8'hFF, 1'b0); slv_q.push_back(1'b1);
        start_cmd(7'h2A, 1'b0, 8'h11);
        wait_bd(bd0 + 1, "mw1");
        data_wr = 8'h22;
        wait_bd(bd0 + 2, "mw2");
        ena = 1'b0;
        end_test("mwr", bd0, 2, 1'b0);

        // Reset while WR drives bit 3 of 0xA5 (a 0, so SDA is pulled)
        bd0 = bd_cnt;
        exp_ev(EV_START, '0);
        exp_ev(EV_FRAME, {8'hA0, 1'b0});
        exp_ev(EV_ABORT, '0);
        slv_byte(8'hFF, 1'b0); slv_byte(8'hFF, 1'b0);
        start_cmd(7'h50, 1'b0, 8'hA5);
        wait_busy(1'b1, "rst_wr");
        ena = 1'b0;
        repeat (14) @(posedge data_clk);
        repeat (3) tick();
        check("wr_bit3_drive", {sda_oe, scl_ena}, 2'b11);
        rst = 1'b1;
        tick();
        check("abort_sda_oe", sda_oe, 1'b0);
        check("abort_scl_ena", scl_ena, 1'b0);
        check("abort_busy", busy, 1'b0);
        rst = 1'b0;
        slv_q.delete();
        repeat (2) tick();
        check("abort_events_left", ev_q.size(), 0);
        check("abort_byte_done", bd_cnt - bd0, 0);

        bd0 = bd_cnt;
        exp_ev(EV_START, '0);
        exp_ev(EV_FRAME, {8'h24, 1'b0});
        exp_ev(EV_FRAME, {8'h5A, 1'b0});
        exp_ev(EV_STOP, '0);
        slv_byte(8'hFF, 1'b0); slv_byte(8'hFF, 1'b0); slv_q.push_back(1'b1);
        start_cmd(7'h12, 1'b0, 8'h5A);
        wait_busy(1'b1, "post_rst");
        ena = 1'b0;
        end_test("post_rst", bd0, 1, 1'b0);

        // Command change mid-write: 0x50 <- 0x33, then 0x51 <- 0x44 after STOP/START
        bd0 = bd_cnt;
        exp_ev(EV_START, '0);
        exp_ev(EV_FRAME, {8'hA0, 1'b0});
        exp_ev(EV_FRAME, {8'h33, 1'b0});
        exp_ev(EV_STOP, '0);
        exp_ev(EV_START, '0);
        exp_ev(EV_FRAME, {8'hA2, 1'b0});
        exp_ev(EV_FRAME, {8'h44, 1'b0});
        exp_ev(EV_STOP, '0);
        slv_byte(8'hFF, 1'b0); slv_byte(8'hFF, 1'b0); slv_q.push_back(1'b1);
        slv_byte(8'hFF, 1'b0); slv_byte(8'hFF, 1'b0); slv_q.push_back(1'b1);
        start_cmd(7'h50, 1'b0, 8'h33);
        wait_bd(bd0 + 1, "chg1");
        addr    = 7'h51;
        data_wr = 8'h44;
        wait_busy(1'b0, "chg_stop");
        wait_busy(1'b1, "chg_restart");
        ena = 1'b0;
        end_test("chg", bd0, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
